pwm_duty_slew: RTL and testbench



---
 rtl/pwm_duty_slew.sv | 147 ++++++++++++++
 tb/tb_pwm_duty_slew.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_slew.sv
// pwm_duty_slew: slew-rate limiter between the duty-cycle register and the
// PWM generator. The delivered duty walks toward the programmed target by at
// most STEP LSBs once every DIV clocks. It never overshoots or wraps.
//
// Parameters:
//   DIV   clocks per slew tick (1..65536)
//   STEP  maximum duty change per tick in LSBs (1..255)
//
// Ports:
//   clk            system clock
//   rst_n          synchronous active-low reset
//   target_duty_i  requested duty (8 bit)
//   hold_i         freeze duty, prescaler and state
//   bypass_i       duty follows target directly, prescaler cleared
//   duty_out_o     slewed duty (registered)
//   state_o        ramp state: 00 IDLE, 01 RAMP_UP, 10 RAMP_DOWN
//   busy_o         high when state is not IDLE (decoded from state)
//   settled_o      one-cycle pulse when a ramp completes
//
// Build option:
//   DUTY_SLEW_SETTLE_PULSE_EN  when defined, settled_o pulses for one cycle
//                              after each ramp -> IDLE transition, including
//                              one forced by bypass. When undefined,
//                              settled_o is tied low.

module pwm_duty_slew #(
  parameter int unsigned DIV  = 256,
  parameter int unsigned STEP = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] target_duty_i,
  input  logic       hold_i,
  input  logic       bypass_i,
  output logic [7:0] duty_out_o,
  output logic [1:0] state_o,
  output logic       busy_o,
  output logic       settled_o
);

  // Prescaler width: clog2(DIV), but never narrower than one bit.
  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    RAMP_UP   = 2'b01,
    RAMP_DOWN = 2'b10
  } state_e;

  logic [7:0]    duty_q,  duty_d;
  logic [PW-1:0] presc_q, presc_d;
  state_e        state_q, state_d;

  logic          tick_c;
  logic          up_c;
  logic          down_c;
  logic [8:0]    diff_c;
  logic [8:0]    step_c;

  // Slew tick fires on the last count of each prescaler period.
  assign tick_c = (presc_q == PW'(DIV - 1));

  // Direction of the pending step and its bounded size.
  always_comb begin
    up_c   = (target_duty_i > duty_q);
    down_c = (target_duty_i < duty_q);
    if (up_c) begin
      diff_c = 9'(target_duty_i) - 9'(duty_q);
    end else begin
      diff_c = 9'(duty_q) - 9'(target_duty_i);
    end
    // Clamping to the distance makes overshoot and wrap impossible.
    step_c = (diff_c < 9'(STEP)) ? diff_c : 9'(STEP);
  end

  // Next duty, prescaler and ramp state. Priority: bypass > hold > normal.
  always_comb begin
    duty_d  = duty_q;
    presc_d = presc_q;
    state_d = state_q;

    if (bypass_i) begin
      duty_d  = target_duty_i;
      presc_d = '0;
    end else if (!hold_i) begin
      presc_d = tick_c ? '0 : presc_q + PW'(1);
      if (tick_c) begin
        if (up_c) begin
          duty_d = 8'(9'(duty_q) + step_c);
        end else if (down_c) begin
          duty_d = 8'(9'(duty_q) - step_c);
        end
      end
    end

    // The state compares the next duty with the target. A retarget therefore
    // leaves IDLE before the first step, and the final step lands in IDLE.
    if (bypass_i || !hold_i) begin
      if (duty_d < target_duty_i) begin
        state_d = RAMP_UP;
      end else if (duty_d > target_duty_i) begin
        state_d = RAMP_DOWN;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_q  <= 8'h00;
      presc_q <= '0;
      state_q <= IDLE;
    end else begin
      duty_q  <= duty_d;
      presc_q <= presc_d;
      state_q <= state_d;
    end
  end

`ifdef DUTY_SLEW_SETTLE_PULSE_EN
  logic settled_q, settled_d;

  // Pulse on any ramp -> IDLE transition. Reset and a steady IDLE give none.
  always_comb begin
    settled_d = (state_q != IDLE) && (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      settled_q <= 1'b0;
    end else begin
      settled_q <= settled_d;
    end
  end

  assign settled_o = settled_q;
`else
  assign settled_o = 1'b0;
`endif

  assign duty_out_o = duty_q;
  assign state_o    = state_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_pwm_duty_slew.sv
// Self-checking bench for pwm_duty_slew with DIV=4, STEP=3.
// Directed scenarios and randomized stimulus. Outputs are compared every
// cycle against a behavioural model that uses signed integer arithmetic.
module tb_pwm_duty_slew;

  localparam int DIV  = 4;
  localparam int STEP = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] target_duty = 8'h00;
  logic       hold = 1'b0;
  logic       bypass = 1'b0;
  wire  [7:0] duty_out;
  wire  [1:0] state;
  wire        busy;
  wire        settled;

  pwm_duty_slew #(.DIV(DIV), .STEP(STEP)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .target_duty_i (target_duty),
    .hold_i        (hold),
    .bypass_i      (bypass),
    .duty_out_o    (duty_out),
    .state_o       (state),
    .busy_o        (busy),
    .settled_o     (settled)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  int m_duty    = 0;
  int m_cnt     = 0;
  int m_state   = 0;
  int m_settled = 0;

  // Duty values seen during a collection window, recorded on each change.
  int q_duty[$];
  int q_state[$];
  int pulses;
  int max_duty;

`ifdef DUTY_SLEW_SETTLE_PULSE_EN
  localparam int PULSE_EN = 1;
`else
  localparam int PULSE_EN = 0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock edge of the behavioural reference model.
  function automatic void model_edge();
    int prev;
    int delta;
    int ns;
    prev = m_state;
    if (!rst_n) begin
      m_duty = 0; m_cnt = 0; m_state = 0; m_settled = 0;
      return;
    end
    if (bypass) begin
      m_duty = int'(target_duty);
      m_cnt  = 0;
    end else if (hold) begin
      m_settled = 0;
      return;
    end else begin
      if (m_cnt == DIV - 1) begin
        delta = int'(target_duty) - m_duty;
        if (delta > STEP)  delta = STEP;
        if (delta < -STEP) delta = -STEP;
        m_duty = m_duty + delta;
      end
      m_cnt = (m_cnt + 1) % DIV;
    end
    if (m_duty < int'(target_duty))      ns = 1;
    else if (m_duty > int'(target_duty)) ns = 2;
    else                                 ns = 0;
    m_settled = (PULSE_EN != 0 && prev != 0 && ns == 0) ? 1 : 0;
    m_state   = ns;
  endfunction

  // Advance one clock, update the model, and compare every output.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("duty", 32'(duty_out), 32'(m_duty));
    chk("state", 32'(state), 32'(m_state));
    chk("busy", 32'(busy), 32'(m_state != 0));
    chk("settled", 32'(settled), 32'(m_settled));
  endtask

  // Run n cycles, logging duty and state changes and settled pulses.
  task automatic collect(input int n);
    int last_d;
    int last_s;
    q_duty.delete();
    q_state.delete();
    pulses   = 0;
    last_d   = int'(duty_out);
    last_s   = int'(state);
    max_duty = last_d;
    q_state.push_back(last_s);
    for (int i = 0; i < n; i++) begin
      cyc();
      if (int'(duty_out) != last_d) begin
        last_d = int'(duty_out);
        q_duty.push_back(last_d);
      end
      if (int'(state) != last_s) begin
        last_s = int'(state);
        q_state.push_back(last_s);
      end
      if (settled) pulses++;
      if (int'(duty_out) > max_duty) max_duty = int'(duty_out);
    end
  endtask

  // Compare a logged sequence with its expected contents.
  task automatic chk_seq(input string tag, input int got[$], input int exp[$]);
    chk({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      chk(tag, 32'(got[i]), 32'(exp[i]));
    end
  endtask

  // Force duty to v and clear the prescaler via one bypass cycle.
  task automatic preset(input logic [7:0] v);
    bypass = 1'b1; target_duty = v;
    cyc();
    bypass = 1'b0;
  endtask

  logic [7:0] frozen;
  int         found;

  initial begin
    // Reset with a nonzero target.
    rst_n = 1'b0; target_duty = 8'h80;
    cyc(); cyc();
    chk("rst_duty", 32'(duty_out), 32'h00);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_settled", 32'(settled), 32'd0);
    rst_n = 1'b1;
    cyc();
    chk("rel_state", 32'(state), 32'd1);

    // Ramp up from reset toward 0x0A.
    rst_n = 1'b0; target_duty = 8'h0A;
    cyc();
    rst_n = 1'b1;
    collect(24);
    chk_seq("up_seq", q_duty, '{3, 6, 9, 10});
    chk_seq("up_state", q_state, '{0, 1, 0});
    chk("up_max", 32'(max_duty), 32'h0A);
    chk("up_pulses", 32'(pulses), 32'(PULSE_EN));

    // Ramp down toward 0x00.
    target_duty = 8'h00;
    collect(24);
    chk_seq("dn_seq", q_duty, '{7, 4, 1, 0});
    chk("dn_pulses", 32'(pulses), 32'(PULSE_EN));

    // Reversal: head toward 0xFF and retarget to 0x02 once duty reaches 0x06.
    target_duty = 8'hFF;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      cyc();
      if (duty_out == 8'h06) found = 1;
    end
    chk("rev_reach6", 32'(found), 32'd1);
    target_duty = 8'h02;
    collect(16);
    chk_seq("rev_seq", q_duty, '{3, 2});
    chk_seq("rev_state", q_state, '{1, 2, 0});

    // Saturation at both ends.
    preset(8'hFD);
    target_duty = 8'hFF;
    for (int i = 0; i < DIV; i++) cyc();
    chk("sat_hi", 32'(duty_out), 32'hFF);
    preset(8'h02);
    target_duty = 8'h00;
    for (int i = 0; i < DIV; i++) cyc();
    chk("sat_lo", 32'(duty_out), 32'h00);

    // Hold mid-ramp: duty frozen, prescaler resumes where it stopped.
    target_duty = 8'h40;
    for (int i = 0; i < 6; i++) cyc();
    frozen = duty_out;
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("hold_frozen", 32'(duty_out), 32'(frozen));
    end
    hold = 1'b0;
    // Two prescaler counts had elapsed before the hold; the step lands two edges later.
    cyc();
    chk("hold_rem1", 32'(duty_out), 32'(frozen));
    cyc();
    chk("hold_rem2", 32'(duty_out), 32'(frozen) + 32'(STEP));

    // Bypass mid-ramp.
    bypass = 1'b1; target_duty = 8'hC0;
    cyc();
    bypass = 1'b0;
    chk("byp_duty", 32'(duty_out), 32'hC0);
    chk("byp_state", 32'(state), 32'd0);
    chk("byp_settled", 32'(settled), 32'(PULSE_EN));
    cyc();
    chk("byp_settled_off", 32'(settled), 32'd0);

    // Hold and bypass together: bypass wins.
    hold = 1'b1; bypass = 1'b1; target_duty = 8'h10;
    cyc();
    hold = 1'b0; bypass = 1'b0;
    chk("hb_duty", 32'(duty_out), 32'h10);

    // Reset mid-ramp at 0x40 heading for 0x80.
    preset(8'h40);
    target_duty = 8'h80;
    cyc(); cyc();
    rst_n = 1'b0;
    cyc();
    chk("mrst_duty", 32'(duty_out), 32'h00);
    rst_n = 1'b1;
    for (int i = 0; i < DIV - 1; i++) cyc();
    chk("mrst_wait", 32'(duty_out), 32'h00);
    cyc();
    chk("mrst_first", 32'(duty_out), 32'h03);

    // Randomized stimulus against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(15, 0) == 0) target_duty = 8'($urandom);
      hold   = ($urandom_range(9, 0) == 0);
      bypass = ($urandom_range(59, 0) == 0);
      rst_n  = ($urandom_range(299, 0) != 0);
      cyc();
    end
    hold = 1'b0; bypass = 1'b0; rst_n = 1'b1;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
